// File: rtl/ps2_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_transmitter
//
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard or
// mouse using the inhibit / request-to-send handshake: clock held low, data
// pulled low (start bit), clock released, then 8 data bits LSB first, odd
// parity and a released stop bit are placed on the data line on each
// device-generated falling clock edge. The device ACK is sampled on the
// 11th falling edge.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   When defined, a 19-bit counter runs from clock release until the bus
//   returns to idle; reaching TIMEOUT_CYCLES aborts with a tx_error pulse.
//   When undefined the block waits indefinitely for device clocks.
//
// Parameters:
//   INHIBIT_CYCLES  clock-low inhibit time in clk cycles (default 100 us @ 25 MHz)
//   TIMEOUT_CYCLES  clock-release-to-idle limit in clk cycles (timeout build only)
//
// Ports:
//   clk          system clock (25 MHz)
//   rst_n        asynchronous active-low reset
//   tx_data      byte to send, sampled on the accept cycle
//   tx_valid     request to send
//   tx_ready     high only in IDLE; accept = tx_valid && tx_ready
//   ps2_clk      PS/2 clock pad (read back)
//   ps2_data     PS/2 data pad (read back)
//   ps2_clk_oe   1 pulls the clock pad low, 0 releases it
//   ps2_data_oe  1 pulls the data pad low, 0 releases it
//   busy         high in every state except IDLE (gates the PS/2 receiver)
//   tx_done      one-cycle pulse: ACK received and bus back to idle
//   tx_error     one-cycle pulse: missing ACK or timeout
// ---------------------------------------------------------------------------
module ps2_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // Inhibit counter only needs to reach INHIBIT_CYCLES-1.
  localparam int unsigned ICW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  // Elaboration-time guard on the configuration (19-bit timeout counter).
  if ((INHIBIT_CYCLES < 1) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 524287)) begin : g_param_check
    $error("ps2_transmitter: INHIBIT_CYCLES/TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic             parity;
  logic [3:0]       bit_cnt;
  logic [ICW-1:0]   icnt;

  // Two-flop synchronisers; bit [1] is the older sample.
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_fall;
  logic             to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_fall = (clk_sync == 2'b10);

`ifdef PS2_TX_TIMEOUT_EN
  logic [18:0] tcnt;
  logic        tracking;

  // Counts every cycle after clock release until the FSM leaves the transfer.
  assign tracking = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP) ||
                    (state == S_ACK)  || (state == S_WAIT_IDLE);
  assign to_hit   = tracking && (tcnt == 19'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (!tracking) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 19'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      icnt        <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      // Timeout wins over any falling edge seen in the same cycle.
      if (to_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_error    <= 1'b1;
        busy        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            if (tx_valid && tx_ready) begin
              shreg      <= tx_data;
              parity     <= ~^tx_data;
              icnt       <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (icnt == ICW'(INHIBIT_CYCLES - 1)) begin
              ps2_data_oe <= 1'b1;
              state       <= S_REQ;
            end else begin
              icnt <= icnt + 1'b1;
            end
          end

          // Start bit already on the line; release the clock to the device.
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            state      <= S_DATA;
          end

          S_DATA: begin
            if (clk_fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[7:1]};
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= S_PARITY;
              end
            end
          end

          S_PARITY: begin
            if (clk_fall) begin
              ps2_data_oe <= ~parity;
              state       <= S_STOP;
            end
          end

          S_STOP: begin
            if (clk_fall) begin
              ps2_data_oe <= 1'b0;
              state       <= S_ACK;
            end
          end

          S_ACK: begin
            if (clk_fall) begin
              if (!data_sync[1]) begin
                state <= S_WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end

          S_WAIT_IDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end
          end

          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ps2_transmitter
//
// Self-checking bench for ps2_transmitter. A behavioural PS/2 device drives
// the open-drain lines, samples the data line before each falling clock edge
// and optionally ACKs. Expected frames are built from the byte with
// $countones for odd parity.
// ---------------------------------------------------------------------------
module tb_ps2_transmitter;

  localparam int unsigned INH = 2500;
  localparam int unsigned TO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       pad_clk;
  logic       pad_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned low_run = 0;
  int unsigned last_low = 0;

  // Open-drain wired-AND with pull-ups.
  assign pad_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign pad_data = ~(ps2_data_oe | dev_data_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (pad_clk),
    .ps2_data   (pad_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Pulse counters and host clock-low run length, sampled mid-cycle.
  always @(posedge clk) begin
    #5;
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_error) err_cnt = err_cnt + 1;
    if (tx_done || tx_error) begin
      checks = checks + 1;
      if ((tx_done && tx_error) || tx_ready) begin
        errors = errors + 1;
        $display("FAIL pulse_excl: done=%b error=%b ready=%b, required one pulse with ready=0",
                 tx_done, tx_error, tx_ready);
      end
    end
    if (ps2_clk_oe) begin
      low_run = low_run + 1;
    end else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Device: waits for clock release, then generates nedges clock pulses,
  // sampling the line before each fall. With nedges < 11 it stops with its
  // clock held low.
  task automatic dev_clock(input int nedges, input bit ack,
                           output logic [10:0] bits, output bit ok);
    bits = '1;
    ok   = 1'b0;
    for (int i = 0; i < int'(INH) + 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    for (int k = 0; k < nedges; k++) begin
      repeat (5) @(negedge clk);
      bits[k] = pad_data;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      if (k == nedges - 1 && nedges < 11) return;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic do_tx(input string name, input logic [7:0] b, input bit ack, input bit spam);
    logic [10:0] got;
    logic [10:0] exp;
    bit          ok;
    int unsigned d0;
    int unsigned e0;
    d0 = done_cnt;
    e0 = err_cnt;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s ready_wait: tx_ready=%b, required 1", name, tx_ready);
      return;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (spam) tx_data = 8'h00;
    else tx_valid = 1'b0;
    checks++;
    if ({ps2_clk_oe, busy, tx_ready} !== 3'b110) begin
      errors++;
      $display("FAIL %s accept: {clk_oe,busy,ready}=%b, required 110", name,
               {ps2_clk_oe, busy, tx_ready});
    end
    dev_clock(11, ack, got, ok);
    exp = frame_of(b);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL %s frame: line bits=%b (release seen %0d), required %b", name, got, ok, exp);
    end
    checks++;
    if (last_low !== INH + 1) begin
      errors++;
      $display("FAIL %s clk_low_len: %0d cycles, required %0d", name, last_low, INH + 1);
    end
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    checks++;
    if (done_cnt - d0 !== (ack ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_count: %0d pulses, required %0d", name, done_cnt - d0, ack ? 1 : 0);
    end
    checks++;
    if (err_cnt - e0 !== (ack ? 0 : 1)) begin
      errors++;
      $display("FAIL %s error_count: %0d pulses, required %0d", name, err_cnt - e0, ack ? 0 : 1);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s released: {clk_oe,data_oe,busy}=%b, required 000", name,
               {ps2_clk_oe, ps2_data_oe, busy});
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after: tx_ready=%b, required 1", name, tx_ready);
    end
    if (spam) begin
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s no_queue: busy=%b clk_oe=%b, required 0 0", name, busy, ps2_clk_oe);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs: {clk_oe,data_oe,ready,busy,done,error}=%b, required 001000",
               {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_error});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_reset: {ready,busy,clk_oe}=%b, required 100",
               {tx_ready, busy, ps2_clk_oe});
    end
  endtask

  task automatic test_known_bytes();
    do_tx("send_F4", 8'hF4, 1'b1, 1'b0);
    do_tx("send_ED", 8'hED, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      do_tx("send_rand", 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
  endtask

  task automatic test_nack();
    do_tx("nack", 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_tx("busy_ignore_FF", 8'hFF, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    bit          ok;
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_clock(5, 1'b0, got, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit4: release=%0d data_oe=%b busy=%b, required 1 1 1", ok, ps2_data_oe, busy);
    end
    #8;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL async_reset: {clk_oe,data_oe,ready,busy}=%b, required 0010",
               {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
    end
    dev_clk_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_tx("after_reset_F4", 8'hF4, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int unsigned t0;
    int unsigned t1;
    int unsigned e0;
    int unsigned d0;
    bit          ok;
    e0 = err_cnt;
    d0 = done_cnt;
    t0 = 0;
    t1 = 0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < int'(INH) + 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        t0 = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_release: clock release not seen, clk_oe=%b", ps2_clk_oe);
    end
`ifdef PS2_TX_TIMEOUT_EN
    ok = 1'b0;
    for (int i = 0; i < int'(TO) + 100; i++) begin
      @(negedge clk);
      if (tx_error) begin
        ok = 1'b1;
        t1 = cyc;
        break;
      end
    end
    checks++;
    if (!ok || (t1 - t0) !== TO) begin
      errors++;
      $display("FAIL timeout_latency: seen=%0d after %0d cycles, required %0d", ok, t1 - t0, TO);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000 || done_cnt != d0) begin
      errors++;
      $display("FAIL timeout_release_lines: {clk_oe,data_oe,busy}=%b done=%0d, required 000 0",
               {ps2_clk_oe, ps2_data_oe, busy}, done_cnt - d0);
    end
    repeat (3) @(negedge clk);
`else
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err_cnt != e0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_busy: busy=%b ready=%b errors=%0d, required 1 0 0",
               busy, tx_ready, err_cnt - e0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_known_bytes();
    test_random();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
